// File: rtl/shift_pipe_pkg.sv
// Shared types for the pipelined barrel shifter: op encodings, the per-stage
// payload carried down the pipe, and a constant log2 helper.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_TAGW  = 16;
  localparam int unsigned AMTW      = 6;

  // Sized for the widest configuration; unused upper bits stay zero.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    op_e                  op;
    logic [AMTW-1:0]      amt;
    logic [MAX_TAGW-1:0]  tag;
    logic                 zap;
    logic                 sign;
  } stage_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Handshake bus of shift_pipe: request side (IN_*) and result side (OUT_*).
interface shift_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 4
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [1:0]       IN_OP;
  logic [WIDTH-1:0] IN_D;
  logic [31:0]      IN_S;
  logic [TAGW-1:0]  IN_TAG;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_Y;
  logic [TAGW-1:0]  OUT_TAG;

  modport master (
    output IN_VALID, IN_OP, IN_D, IN_S, IN_TAG, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_Y, OUT_TAG
  );

  modport slave (
    input  IN_VALID, IN_OP, IN_D, IN_S, IN_TAG, OUT_READY,
    output IN_READY, OUT_VALID, OUT_Y, OUT_TAG
  );
endinterface

// File: rtl/shift_pipe_stage.sv
// One registered step of the shifter: applies distance DIST when the low
// remaining amount bit is set, then retires that bit.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   up_valid,
  output logic   up_ready,
  input  stage_t up_pay,
  output logic   valid,
  input  logic   dn_ready,
  output stage_t pay
);

  stage_t           stepped;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] fill;

  always_comb begin
    stepped = up_pay;
    d       = up_pay.data[WIDTH-1:0];
    fill    = (up_pay.op == OP_SRA && up_pay.sign) ? '1 : '0;
    if (up_pay.amt[0]) begin
      case (up_pay.op)
        OP_SLL:         d = d << DIST;
        OP_SRL, OP_SRA: d = (d >> DIST) | (fill << (WIDTH - DIST));
        OP_ROR:         d = (d >> DIST) | (d << (WIDTH - DIST));
      endcase
    end
    stepped.data[WIDTH-1:0] = d;
    // Next stage always inspects bit 0 of what remains.
    stepped.amt = up_pay.amt >> 1;
  end

  assign up_ready = !valid || dn_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      pay   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) pay <= stepped;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: log2(WIDTH) registered stages with valid/ready,
// tag sideband, flush, and oversize-amount (zap) handling at the output.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 4
) (
  input logic          CLK,
  input logic          RST,
  input logic          FLUSH,
  shift_pipe_if.slave  bus
);

  localparam int unsigned SHW = clog2(WIDTH);

  stage_t           pay   [SHW+1];
  logic             valid [SHW+1];
  logic             ready [SHW+1];
  stage_t           entry;
  stage_t           last;
  logic [WIDTH-1:0] y;
  logic             unused_last;

  always_comb begin
    entry                  = '0;
    entry.data[WIDTH-1:0]  = bus.IN_D;
    entry.op               = op_e'(bus.IN_OP);
    entry.amt[SHW-1:0]     = bus.IN_S[SHW-1:0];
    entry.tag[TAGW-1:0]    = bus.IN_TAG;
    entry.zap              = |bus.IN_S[31:SHW];
    entry.sign             = bus.IN_D[WIDTH-1];
  end

  assign pay[0]       = entry;
  assign valid[0]     = bus.IN_VALID && !FLUSH;
  assign ready[SHW]   = bus.OUT_READY;
  assign bus.IN_READY = ready[0] && !FLUSH;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .clk      (CLK),
      .rst      (RST),
      .flush    (FLUSH),
      .up_valid (valid[k]),
      .up_ready (ready[k]),
      .up_pay   (pay[k]),
      .valid    (valid[k+1]),
      .dn_ready (ready[k+1]),
      .pay      (pay[k+1])
    );
  end

  assign last = pay[SHW];

  // Amounts >= WIDTH: rotate already wrapped mod WIDTH; the others saturate.
  always_comb begin
    y = last.data[WIDTH-1:0];
    if (last.zap) begin
      case (last.op)
        OP_SLL, OP_SRL: y = '0;
        OP_SRA:         y = {WIDTH{last.sign}};
        default:        y = last.data[WIDTH-1:0];
      endcase
    end
  end

  assign bus.OUT_VALID = valid[SHW];
  assign bus.OUT_Y     = y;
  assign bus.OUT_TAG   = last.tag[TAGW-1:0];
  assign unused_last   = ^last;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (WIDTH=32, TAGW=4).
module tb_shift_pipe;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  shift_pipe_if #(.WIDTH(32), .TAGW(4)) bus ();

  shift_pipe #(.WIDTH(32), .TAGW(4)) dut (
    .CLK   (clk),
    .RST   (rst),
    .FLUSH (flush),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] y;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_done;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [31:0] s);
    logic [63:0] dd;
    logic [31:0] r;
    case (op)
      2'b00: r = (s >= 32) ? 32'd0 : d << s;
      2'b01: r = (s >= 32) ? 32'd0 : d >> s;
      2'b10: begin
        if (s >= 32) r = {32{d[31]}};
        else         r = $signed(d) >>> s;
      end
      default: begin
        dd = {d, d} >> (s % 32);
        r  = dd[31:0];
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got y=%h tag=%0d, want no output", bus.OUT_Y, bus.OUT_TAG);
      end else begin
        e = sb.pop_front();
        if (bus.OUT_Y !== e.y || bus.OUT_TAG !== e.tag) begin
          bad++;
          $display("FAIL result: got y=%h tag=%0d, want y=%h tag=%0d",
                   bus.OUT_Y, bus.OUT_TAG, e.y, e.tag);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [31:0] s,
                       input logic [3:0] tag, input logic [31:0] exp, input bit keep);
    bit   rdy;
    exp_t e;
    bus.IN_VALID = 1'b1;
    bus.IN_OP    = op;
    bus.IN_D     = d;
    bus.IN_S     = s;
    bus.IN_TAG   = tag;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rdy = bus.IN_READY;
      @(posedge clk);
      #1;
      if (rdy) begin
        if (keep) begin
          e.y   = exp;
          e.tag = tag;
          sb.push_back(e);
        end
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL issue_timeout: IN_READY=%b, want 1 within 300 cycles", bus.IN_READY);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d results outstanding, want 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    rst           = 1'b0;
    flush         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.IN_OP     = 2'b00;
    bus.IN_D      = '0;
    bus.IN_S      = '0;
    bus.IN_TAG    = '0;
    bus.OUT_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus.OUT_VALID);
    end
    total++;
    if (bus.OUT_Y !== 32'd0) begin
      bad++; $display("FAIL reset_out_y: got %h want 00000000", bus.OUT_Y);
    end
    total++;
    if (bus.OUT_TAG !== 4'd0) begin
      bad++; $display("FAIL reset_out_tag: got %0d want 0", bus.OUT_TAG);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.IN_READY !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", bus.IN_READY);
    end
  endtask

  task automatic test_modes;
    logic [31:0] expv [4];
    int          cyc;
    expv = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h1800_000F};
    for (int unsigned m = 0; m < 4; m++) begin
      issue(2'(m), 32'h8000_00F1, 32'd4, 4'(m + 5), expv[m], 1'b1);
      bus.IN_VALID = 1'b0;
      cyc = 1;
      while (bus.OUT_VALID !== 1'b1 && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      total++;
      if (cyc != 5) begin
        bad++; $display("FAIL mode%0d_latency: got %0d cycles want 5", m, cyc);
      end
      @(posedge clk);
      #1;
    end
    wait_drain("modes");
  endtask

  task automatic test_large;
    logic [1:0]  ops  [9];
    logic [31:0] amts [9];
    logic [31:0] expv [9];
    ops  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    amts = '{32'd32, 32'd32, 32'd32, 32'd32, 32'hFFFF_FFE1, 32'd31, 32'd0, 32'd0, 32'd33};
    expv = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8000_0001, 32'hC000_0000,
             32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 32'hC000_0000};
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], 32'h8000_0001, amts[i], 4'(i), expv[i], 1'b1);
    end
    bus.IN_VALID = 1'b0;
    wait_drain("large");
  endtask

  task automatic test_back_pressure;
    int          i   = 0;
    int          cyc = 0;
    int          rel = -1;
    bit          rdy;
    exp_t        e;
    logic [31:0] d;
    bus.OUT_READY = 1'b0;
    bus.IN_VALID  = 1'b1;
    while (i < 10 && cyc < 200) begin
      d          = 32'hC0DE_0000 | 32'(i);
      bus.IN_OP  = 2'b10;
      bus.IN_D   = d;
      bus.IN_S   = 32'(i);
      bus.IN_TAG = i[3:0];
      @(negedge clk);
      rdy = bus.IN_READY;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) begin
        e.y   = model(2'b10, d, 32'(i));
        e.tag = i[3:0];
        sb.push_back(e);
        i++;
      end else if (rel < 0) begin
        total++;
        if (i != 5) begin
          bad++; $display("FAIL stall_depth: got %0d accepts want 5", i);
        end
        bus.OUT_READY = 1'b1;
        #1;
        total++;
        if (bus.IN_READY !== 1'b1) begin
          bad++; $display("FAIL ready_reassert: got %b want 1", bus.IN_READY);
        end
        rel = cyc;
      end
    end
    bus.IN_VALID = 1'b0;
    total++;
    if (rel < 0) begin
      bad++; $display("FAIL stall_seen: IN_READY never dropped, want drop after 5 accepts");
    end
    while (sb.size() != 0 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (cyc - rel != 10) begin
      bad++; $display("FAIL drain_cycles: got %0d cycles want 10", cyc - rel);
    end
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] d;
    logic [31:0] s;
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          op = 2'($urandom_range(0, 3));
          d  = $urandom;
          s  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 33));
          issue(op, d, s, 4'(n), model(op, d, s), 1'b1);
          if ($urandom_range(0, 3) == 0) begin
            bus.IN_VALID = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        bus.IN_VALID = 1'b0;
        rand_done    = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.OUT_READY = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.OUT_READY = 1'b1;
    wait_drain("random");
  endtask

  task automatic test_flush;
    int cyc;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(2'b01, 32'hDEAD_BEEF, 32'(i), 4'(i + 1), 32'd0, 1'b0);
    end
    flush      = 1'b1;
    bus.IN_D   = 32'h1111_1111;
    bus.IN_TAG = 4'd4;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (bus.IN_READY !== 1'b0) begin
        bad++; $display("FAIL flush_in_ready: cycle %0d got %b want 0", c, bus.IN_READY);
      end
      @(posedge clk);
      #1;
    end
    flush        = 1'b0;
    bus.IN_VALID = 1'b0;
    #1;
    total++;
    if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
      bad++; $display("FAIL flush_cleared: got out_valid=%b in_ready=%b want 0/1",
                      bus.OUT_VALID, bus.IN_READY);
    end
    issue(2'b00, 32'h0000_0001, 32'd3, 4'hF, 32'h0000_0008, 1'b1);
    bus.IN_VALID = 1'b0;
    cyc = 1;
    while (bus.OUT_VALID !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (cyc != 5) begin
      bad++; $display("FAIL flush_latency: got %0d cycles want 5", cyc);
    end
    repeat (10) @(posedge clk);
    #1;
    wait_drain("flush");
  endtask

  task automatic test_reset_mid;
    bus.OUT_READY = 1'b0;
    issue(2'b11, 32'h1234_5678, 32'd8, 4'd9, 32'd0, 1'b0);
    issue(2'b00, 32'h1234_5678, 32'd1, 4'd10, 32'd0, 1'b0);
    bus.IN_VALID = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.OUT_READY = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (bus.OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL reset_mid_discard: out_valid=%b want 0", bus.OUT_VALID);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_large();
    test_back_pressure();
    test_random();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
